// File: rtl/reset_seq_pkg.sv
// -----------------------------------------------------------------------------
// reset_seq_pkg
// Shared types and constants for the staged reset sequencer.
//   seq_state_t : controller state (IDLE, RELEASE, RUN, ASSERT, FAULT), 3-bit
//   MAX_RESETS  : largest supported number of staged reset outputs
//   IDX_W       : width of the stage index, wide enough for 0..MAX_RESETS
// -----------------------------------------------------------------------------
package reset_seq_pkg;

   localparam int MAX_RESETS = 16;
   localparam int IDX_W      = $clog2(MAX_RESETS + 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RELEASE = 3'd1,
      RUN     = 3'd2,
      ASSERT  = 3'd3,
      FAULT   = 3'd4
   } seq_state_t;

endpackage

// File: rtl/reset_seq_sync.sv
// -----------------------------------------------------------------------------
// reset_seq_sync
// Two-flop synchronizer for a single level input. Both flops clear to 0 on
// the asynchronous active-low reset.
// Ports:
//   i_clock   : destination clock
//   i_reset_n : asynchronous active-low reset
//   i_d       : asynchronous level input
//   o_q       : synchronized level output (2 clock edges of latency)
// -----------------------------------------------------------------------------
module reset_seq_sync (
   input  logic i_clock,
   input  logic i_reset_n,
   input  logic i_d,
   output logic o_q
);

   logic [1:0] r_sync;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_sync <= 2'b00;
      end else begin
         r_sync <= {r_sync[0], i_d};
      end
   end

   assign o_q = r_sync[1];

endmodule

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
// Releases NUM_RESETS active-high reset conduits in ascending order with
// DELAY_CYCLES clocks between stages, re-asserts them in reverse order when
// the request drops, and asserts all of them at once on a fault.
//
// Parameters:
//   NUM_RESETS   : number of staged reset outputs (1..16)
//   DELAY_CYCLES : clocks between consecutive stage transitions (>= 1)
// Ports:
//   clock      : system clock
//   reset_n    : asynchronous active-low reset
//   enable     : level request, 1 = release resets, 0 = assert resets
//   fault      : level, 1 = assert all resets on the next edge
//   areset_out : reset conduits, bit k is stage k (1 = held in reset)
//   seq_done   : every stage released and controller in RUN
//   busy       : controller in RELEASE or ASSERT
//   in_fault   : controller in FAULT
//
// Build option RESET_SEQ_SYNC_EN: when defined, enable and fault pass through
// two-flop synchronizers first, adding 2 cycles to every response latency.
// -----------------------------------------------------------------------------
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NUM_RESETS   = 4,
   parameter int DELAY_CYCLES = 1000
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic                  fault,
   output logic [NUM_RESETS-1:0] areset_out,
   output logic                  seq_done,
   output logic                  busy,
   output logic                  in_fault
);

   localparam int CNT_W = $clog2(DELAY_CYCLES + 1);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RESETS);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DELAY_CYCLES - 1);

   seq_state_t            r_state;
   logic [IDX_W-1:0]      r_idx;
   logic [CNT_W-1:0]      r_cnt;
   logic [NUM_RESETS-1:0] r_areset;
   logic                  r_seq_done;
   logic                  r_busy;
   logic                  r_in_fault;

   logic                  w_enable;
   logic                  w_fault;
   logic                  w_cnt_done;
   logic [IDX_W-1:0]      w_idx_up;
   logic [IDX_W-1:0]      w_idx_dn;
   logic [NUM_RESETS-1:0] w_mask_up;
   logic [NUM_RESETS-1:0] w_mask_dn;

`ifdef RESET_SEQ_SYNC_EN
   reset_seq_sync u_sync_enable (
      .i_clock   (clock),
      .i_reset_n (reset_n),
      .i_d       (enable),
      .o_q       (w_enable)
   );

   reset_seq_sync u_sync_fault (
      .i_clock   (clock),
      .i_reset_n (reset_n),
      .i_d       (fault),
      .o_q       (w_fault)
   );
`else
   assign w_enable = enable;
   assign w_fault  = fault;
`endif

   // Counter saturates at LAST_CNT; reaching it marks the end of one stage gap.
   assign w_cnt_done = (r_cnt >= LAST_CNT);

   // Index neighbours, saturating at both ends so idx never wraps.
   assign w_idx_up = (r_idx == LAST_IDX) ? LAST_IDX : r_idx + 1'b1;
   assign w_idx_dn = (r_idx == '0)       ? '0       : r_idx - 1'b1;

   // Conduit patterns for the neighbouring indices: stage k held while k >= idx.
   for (genvar gi = 0; gi < NUM_RESETS; gi++) begin : g_mask
      assign w_mask_up[gi] = (IDX_W'(gi) >= w_idx_up);
      assign w_mask_dn[gi] = (IDX_W'(gi) >= w_idx_dn);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_idx      <= '0;
         r_cnt      <= '0;
         r_areset   <= '1;
         r_seq_done <= 1'b0;
         r_busy     <= 1'b0;
         r_in_fault <= 1'b0;
      end else if (w_fault) begin
         r_state    <= FAULT;
         r_idx      <= '0;
         r_cnt      <= '0;
         r_areset   <= '1;
         r_seq_done <= 1'b0;
         r_busy     <= 1'b0;
         r_in_fault <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_enable) begin
                  r_state <= RELEASE;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
            end

            RELEASE: begin
               if (!w_enable) begin
                  // Reversal keeps idx and restarts the gap; no stage moves here.
                  r_state <= ASSERT;
                  r_cnt   <= '0;
               end else if (w_cnt_done) begin
                  r_cnt    <= '0;
                  r_idx    <= w_idx_up;
                  r_areset <= w_mask_up;
                  if (w_idx_up == LAST_IDX) begin
                     r_state    <= RUN;
                     r_busy     <= 1'b0;
                     r_seq_done <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            RUN: begin
               if (!w_enable) begin
                  r_state    <= ASSERT;
                  r_cnt      <= '0;
                  r_busy     <= 1'b1;
                  r_seq_done <= 1'b0;
               end
            end

            ASSERT: begin
               if (w_enable) begin
                  r_state <= RELEASE;
                  r_cnt   <= '0;
               end else if (w_cnt_done) begin
                  r_cnt    <= '0;
                  r_idx    <= w_idx_dn;
                  r_areset <= w_mask_dn;
                  if (w_idx_dn == '0) begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            FAULT: begin
               // Leaving FAULT requires the request to be withdrawn as well.
               if (!w_enable) begin
                  r_state    <= IDLE;
                  r_in_fault <= 1'b0;
               end
            end

            default: begin
               r_state    <= IDLE;
               r_idx      <= '0;
               r_cnt      <= '0;
               r_areset   <= '1;
               r_seq_done <= 1'b0;
               r_busy     <= 1'b0;
               r_in_fault <= 1'b0;
            end
         endcase
      end
   end

   assign areset_out = r_areset;
   assign seq_done   = r_seq_done;
   assign busy       = r_busy;
   assign in_fault   = r_in_fault;

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Controller that drives a bank of staged reset conduits.
- On request, releases NUM_RESETS active-high reset outputs in ascending order, with a fixed delay between stages.
- On request drop, re-asserts them in reverse order; on fault, asserts all of them at once.
- Sits between the power-sequencer control logic and the per-rail/per-domain reset conduit outputs.

Parameters:
- NUM_RESETS, 4, number of staged reset outputs; legal range 1..16.
- DELAY_CYCLES, 1000, clock cycles between consecutive stage transitions; minimum 1.
- CNT_W, $clog2(DELAY_CYCLES+1), delay counter width; derived, not overridden.

Ports:
- clock  input  1  single system clock.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  level request: 1 = sequence resets out, 0 = sequence resets in.
- fault  input  1  level; 1 = assert all resets immediately.
- areset_out  output  NUM_RESETS  active-high reset conduits; bit k is stage k.
- seq_done  output  1  1 only while every stage is released and the block is in RUN.
- busy  output  1  1 while in RELEASE or ASSERT.
- in_fault  output  1  1 while in FAULT.

Behaviour:
- All outputs are registered. Reset values: areset_out = all ones, seq_done = 0, busy = 0, in_fault = 0, state = IDLE, stage index = 0, counter = 0.
- Stage index idx ranges 0..NUM_RESETS. It counts released stages; areset_out[k] = (k >= idx).
- IDLE:
  - All resets asserted.
  - enable = 1 sampled → RELEASE, counter cleared.
- RELEASE:
  - Counter increments each cycle.
  - When the counter reaches DELAY_CYCLES-1: idx increments, counter clears.
  - Release latency: with enable first sampled high at edge t, stage k deasserts at edge t + (k+1)*DELAY_CYCLES.
  - When idx reaches NUM_RESETS → RUN. seq_done rises on the same edge as the last stage release.
- RUN:
  - All resets released, seq_done = 1.
  - enable = 0 → ASSERT, counter cleared, seq_done drops on the next edge.
- ASSERT:
  - Same counter cadence as RELEASE, but idx decrements.
  - Stage NUM_RESETS-1 asserts first and stage 0 asserts last.
  - When idx reaches 0 → IDLE.
- Reversal mid-sequence:
  - enable drops during RELEASE → ASSERT, keeping the current idx, counter cleared.
  - enable rises during ASSERT → RELEASE, keeping the current idx, counter cleared.
  - No stage ever toggles on the reversal edge itself.
- FAULT:
  - fault = 1 in any state → next edge: areset_out = all ones, idx = 0, state = FAULT, busy = 0, seq_done = 0, in_fault = 1.
  - Exit to IDLE only when fault = 0 and enable = 0 are sampled together. A still-high enable holds the block in FAULT, so a fault must be explicitly acknowledged by dropping enable.
- Priority: fault > enable change > counter advance.
- Asynchronous reset_n assertion mid-sequence: all resets assert immediately (asynchronously) and the block returns to IDLE.
- Counter and idx never wrap: idx saturates at 0 and NUM_RESETS; the counter saturates at DELAY_CYCLES-1.

Optional Feature:
- Macro: RESET_SEQ_SYNC_EN.
- Defined: enable and fault each pass through a 2-flop synchronizer clocked by clock (flops reset to 0). All response latencies grow by 2 cycles; the fault-to-assert latency becomes 3 edges.
- Undefined: enable and fault are used directly and must be synchronous to clock; fault-to-assert latency is 1 edge.

Decomposition:
- Package reset_seq_pkg:
  - state enum typedef seq_state_t {IDLE, RELEASE, RUN, ASSERT, FAULT}, 3-bit encoding.
  - localparam MAX_RESETS = 16.
- Sub-module reset_seq_sync: a 2-flop synchronizer with an asynchronous active-low reset. It is instantiated twice, only when RESET_SEQ_SYNC_EN is defined.

Test Plan (NUM_RESETS = 4, DELAY_CYCLES = 10, macro undefined unless noted):
- Power-up: reset_n low then high, enable = 0 → areset_out = 4'b1111, seq_done = 0, busy = 0 held for 50 cycles.
- Release: enable high at edge t → areset_out = 1110 @ t+10, 1100 @ t+20, 1000 @ t+30, 0000 @ t+40; seq_done = 1 @ t+40.
- Assert: from RUN, enable low at edge u → 1000 @ u+10, 1100 @ u+20, 1110 @ u+30, 1111 @ u+40, then IDLE.
- Reversal: enable low at t+25 (areset_out = 1100) → 1110 @ t+35, 1111 @ t+45, no glitch at t+25.
- Fault: fault = 1 at t+32 with enable = 1 → 1111 and in_fault = 1 @ t+33. Clearing fault with enable still 1 keeps FAULT; dropping enable → IDLE the next edge.
- Sync variant (RESET_SEQ_SYNC_EN): repeat Release → first release at t+12; fault asserts all at +3 edges.
